// File: rtl/calendar_pkg.sv
// Shared types and month-length helper for the watch calendar.
// Feb 29 in years with year[1:0]==0 only when CALENDAR_LEAP_EN is defined.
package calendar_pkg;

    typedef enum logic {
        ST_RUN,
        ST_EDIT
    } state_t;

    localparam logic [1:0] FLD_YEAR  = 2'd0;
    localparam logic [1:0] FLD_MONTH = 2'd1;
    localparam logic [1:0] FLD_DAY   = 2'd2;

`ifdef CALENDAR_LEAP_EN
    localparam bit LEAP_EN = 1'b1;
`else
    localparam bit LEAP_EN = 1'b0;
`endif

    function automatic logic [6:0] days_in_month(
        input logic [1:0] year,
        input logic [6:0] month
    );
        logic [6:0] d;
        case (month)
            7'd4, 7'd6, 7'd9, 7'd11: d = 7'd30;
            // leap term folds to constant 28 when the feature is off
            7'd2:    d = (LEAP_EN && year == 2'd0) ? 7'd29 : 7'd28;
            default: d = 7'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold-to-repeat pulse generator.
// step fires at hold cycle DLY, then every PER cycles while held.
module btn_repeat #(
    parameter int DLY = 12_500_000,
    parameter int PER = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise,
    output logic step
);

    localparam int MX = (DLY > PER) ? DLY : PER;
    localparam int CW = $clog2(MX + 1);

    logic          prev;
    logic          first;
    logic [CW-1:0] cnt;

    assign rise = btn & ~prev;
    assign step = btn & (first ? (cnt == CW'(DLY))
                               : (cnt == CW'(PER)));

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            first <= 1'b1;
            cnt   <= '0;
        end else begin
            prev <= btn;
            if (!btn) begin
                first <= 1'b1;
                cnt   <= '0;
            end else if (step) begin
                first <= 1'b0;
                cnt   <= CW'(1);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calendar_keeper.sv
// Date keeper with button-driven edit mode, blink and auto-repeat.
// Leap-year February enabled by defining CALENDAR_LEAP_EN.
module calendar_keeper #(
    parameter int YEAR_W     = 7,
    parameter int YEAR_MAX   = 99,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int REPEAT_DLY = 12_500_000,
    parameter int REPEAT_PER = 2_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              day_tick,
    input  logic              up,
    input  logic              down,
    input  logic              left,
    input  logic              right,
    input  logic              enter,
    input  logic              esc,
    output logic              norm,
    output logic [1:0]        sel,
    output logic              blink,
    output logic [YEAR_W-1:0] year,
    output logic [6:0]        month,
    output logic [6:0]        day
);

    import calendar_pkg::*;

    localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BTOP = BW'(BLINK_DIV - 1);

    state_t state_q, state_n;

    logic [YEAR_W-1:0] live_y, edit_y, ly_n, ey_n, tk_y;
    logic [6:0]        live_m, edit_m, lm_n, em_n, tk_m;
    logic [6:0]        live_d, edit_d, ld_n, ed_n, tk_d;
    logic [6:0]        ldim, edim, ndim;
    logic [1:0]        sel_n;
    logic [BW-1:0]     bcnt, bcnt_n;
    logic              blink_n;

    logic prev_esc, prev_ent, prev_lft, prev_rgt;
    logic e_esc, e_ent, e_lft, e_rgt;
    logic up_rise, up_rpt, dn_rise, dn_rpt;
    logic hi, any_e;
    logic w_esc, w_ent, w_lft, w_rgt;
    logic inc, dec;

    btn_repeat #(.DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_up (
        .clk  (clk),
        .rst  (rst),
        .btn  (up),
        .rise (up_rise),
        .step (up_rpt)
    );

    btn_repeat #(.DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_dn (
        .clk  (clk),
        .rst  (rst),
        .btn  (down),
        .rise (dn_rise),
        .step (dn_rpt)
    );

    assign e_esc = esc & ~prev_esc;
    assign e_ent = enter & ~prev_ent;
    assign e_lft = left & ~prev_lft;
    assign e_rgt = right & ~prev_rgt;

    // only the highest-priority edge acts; repeats yield to any edge
    assign hi    = e_esc | e_ent;
    assign any_e = hi | up_rise | dn_rise | e_lft | e_rgt;
    assign w_esc = e_esc;
    assign w_ent = e_ent & ~e_esc;
    assign w_lft = e_lft & ~hi & ~up_rise & ~dn_rise;
    assign w_rgt = e_rgt & ~hi & ~up_rise & ~dn_rise & ~e_lft;
    assign inc   = (up_rise & ~hi) | (up_rpt & ~any_e);
    assign dec   = (dn_rise & ~hi & ~up_rise)
                 | (dn_rpt & ~any_e & ~up_rpt);

    always_comb begin
        ldim = days_in_month(live_y[1:0], live_m);
        tk_y = live_y;
        tk_m = live_m;
        tk_d = live_d + 7'd1;
        if (live_d >= ldim) begin
            tk_d = 7'd1;
            if (live_m == 7'd12) begin
                tk_m = 7'd1;
                tk_y = (live_y == YMAX) ? '0 : live_y + 1'b1;
            end else begin
                tk_m = live_m + 7'd1;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        sel_n   = sel;
        bcnt_n  = bcnt;
        blink_n = blink;
        ly_n    = day_tick ? tk_y : live_y;
        lm_n    = day_tick ? tk_m : live_m;
        ld_n    = day_tick ? tk_d : live_d;
        ey_n    = edit_y;
        em_n    = edit_m;
        ed_n    = edit_d;
        edim    = days_in_month(edit_y[1:0], edit_m);
        ndim    = edim;

        unique case (state_q)
            ST_RUN: begin
                if (w_ent) begin
                    state_n = ST_EDIT;
                    ey_n    = ly_n;
                    em_n    = lm_n;
                    ed_n    = ld_n;
                    sel_n   = FLD_YEAR;
                    bcnt_n  = '0;
                    blink_n = 1'b0;
                end
            end
            ST_EDIT: begin
                if (bcnt == BTOP) begin
                    bcnt_n  = '0;
                    blink_n = ~blink;
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
                unique case (1'b1)
                    w_esc: begin
                        state_n = ST_RUN;
                        bcnt_n  = '0;
                        blink_n = 1'b0;
                    end
                    w_ent: begin
                        state_n = ST_RUN;
                        ly_n    = edit_y;
                        lm_n    = edit_m;
                        ld_n    = edit_d;
                        bcnt_n  = '0;
                        blink_n = 1'b0;
                    end
                    (inc | dec): begin
                        unique case (sel)
                            FLD_YEAR: begin
                                if (inc)
                                    ey_n = (edit_y == YMAX) ? '0
                                         : edit_y + 1'b1;
                                else
                                    ey_n = (edit_y == '0) ? YMAX
                                         : edit_y - 1'b1;
                            end
                            FLD_MONTH: begin
                                if (inc)
                                    em_n = (edit_m == 7'd12) ? 7'd1
                                         : edit_m + 7'd1;
                                else
                                    em_n = (edit_m <= 7'd1) ? 7'd12
                                         : edit_m - 7'd1;
                            end
                            default: begin
                                if (inc)
                                    ed_n = (edit_d >= edim) ? 7'd1
                                         : edit_d + 7'd1;
                                else
                                    ed_n = (edit_d <= 7'd1) ? edim
                                         : edit_d - 7'd1;
                            end
                        endcase
                        // keep day legal after a year or month change
                        ndim = days_in_month(ey_n[1:0], em_n);
                        if (ed_n > ndim)
                            ed_n = ndim;
                    end
                    w_lft: begin
                        sel_n = (sel == FLD_YEAR) ? FLD_DAY
                              : sel - 2'd1;
                    end
                    w_rgt: begin
                        sel_n = (sel == FLD_DAY) ? FLD_YEAR
                              : sel + 2'd1;
                    end
                    default: ;
                endcase
            end
            default: state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            live_y   <= '0;
            live_m   <= 7'd1;
            live_d   <= 7'd1;
            edit_y   <= '0;
            edit_m   <= 7'd1;
            edit_d   <= 7'd1;
            bcnt     <= '0;
            prev_esc <= 1'b0;
            prev_ent <= 1'b0;
            prev_lft <= 1'b0;
            prev_rgt <= 1'b0;
            norm     <= 1'b1;
            sel      <= FLD_YEAR;
            blink    <= 1'b0;
            year     <= '0;
            month    <= 7'd1;
            day      <= 7'd1;
        end else begin
            state_q  <= state_n;
            live_y   <= ly_n;
            live_m   <= lm_n;
            live_d   <= ld_n;
            edit_y   <= ey_n;
            edit_m   <= em_n;
            edit_d   <= ed_n;
            bcnt     <= bcnt_n;
            prev_esc <= esc;
            prev_ent <= enter;
            prev_lft <= left;
            prev_rgt <= right;
            norm     <= (state_n == ST_RUN);
            sel      <= sel_n;
            blink    <= blink_n;
            year     <= (state_n == ST_RUN) ? ly_n : ey_n;
            month    <= (state_n == ST_RUN) ? lm_n : em_n;
            day      <= (state_n == ST_RUN) ? ld_n : ed_n;
        end
    end

endmodule

// File: tb/tb_calendar_keeper.sv
// Directed bench for calendar_keeper with short blink/repeat timing.
// Expected February length follows CALENDAR_LEAP_EN.
module tb_calendar_keeper;

    localparam int B_UP  = 0;
    localparam int B_DN  = 1;
    localparam int B_LFT = 2;
    localparam int B_RGT = 3;
    localparam int B_ENT = 4;
    localparam int B_ESC = 5;
    localparam int B_TCK = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       day_tick = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       enter = 1'b0;
    logic       esc = 1'b0;
    logic       norm;
    logic [1:0] sel;
    logic       blink;
    logic [6:0] year;
    logic [6:0] month;
    logic [6:0] day;

    int checks = 0;
    int failures = 0;

    calendar_keeper #(
        .YEAR_W     (7),
        .YEAR_MAX   (99),
        .BLINK_DIV  (4),
        .REPEAT_DLY (8),
        .REPEAT_PER (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .day_tick (day_tick),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .enter    (enter),
        .esc      (esc),
        .norm     (norm),
        .sel      (sel),
        .blink    (blink),
        .year     (year),
        .month    (month),
        .day      (day)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_date(input string tag, input int y,
                            input int m, input int d);
        check({tag, ".year"}, 32'(year), y);
        check({tag, ".month"}, 32'(month), m);
        check({tag, ".day"}, 32'(day), d);
    endtask

    function automatic int dim(input int y, input int m);
        if (m == 2) begin
`ifdef CALENDAR_LEAP_EN
            return (y % 4 == 0) ? 29 : 28;
`else
            return 28;
`endif
        end
        if (m == 4 || m == 6 || m == 9 || m == 11)
            return 30;
        return 31;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input int b, input logic v);
        case (b)
            B_UP:    up = v;
            B_DN:    down = v;
            B_LFT:   left = v;
            B_RGT:   right = v;
            B_ENT:   enter = v;
            B_ESC:   esc = v;
            default: day_tick = v;
        endcase
    endtask

    task automatic pulse(input int b, input int n);
        repeat (n) begin
            drv(b, 1'b1);
            cyc(1);
            drv(b, 1'b0);
            cyc(1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    // assumes RUN at 0/1/1
    task automatic set_date(input int y, input int m, input int d);
        int dm;
        pulse(B_ENT, 1);
        if (y > 50) pulse(B_DN, 100 - y);
        else        pulse(B_UP, y);
        pulse(B_RGT, 1);
        if (m > 6) pulse(B_DN, 13 - m);
        else       pulse(B_UP, m - 1);
        pulse(B_RGT, 1);
        dm = dim(y, m);
        if (d > dm / 2) pulse(B_DN, dm - d + 1);
        else            pulse(B_UP, d - 1);
        pulse(B_ENT, 1);
    endtask

    initial begin
        do_reset();
        chk_date("rst", 0, 1, 1);
        check("rst.norm", 32'(norm), 1);
        check("rst.sel", 32'(sel), 0);
        check("rst.blink", 32'(blink), 0);

        pulse(B_ENT, 1);
        check("edit.norm", 32'(norm), 0);
        do_reset();
        check("rst_mid.norm", 32'(norm), 1);

        set_date(0, 2, 28);
        chk_date("set0228", 0, 2, 28);
        pulse(B_TCK, 1);
`ifdef CALENDAR_LEAP_EN
        chk_date("leap_tick", 0, 2, 29);
`else
        chk_date("leap_tick", 0, 3, 1);
`endif
        do_reset();
        set_date(1, 2, 28);
        pulse(B_TCK, 1);
        chk_date("feb01_tick", 1, 3, 1);

        do_reset();
        set_date(99, 12, 31);
        chk_date("set991231", 99, 12, 31);
        pulse(B_TCK, 1);
        chk_date("year_wrap", 0, 1, 1);

        do_reset();
        set_date(0, 1, 31);
        pulse(B_ENT, 1);
        check("e4.norm", 32'(norm), 0);
        check("e4.sel", 32'(sel), 0);
        cyc(2);
        check("blink_lo", 32'(blink), 0);
        cyc(1);
        check("blink_hi", 32'(blink), 1);
        pulse(B_RGT, 1);
        check("e4.sel1", 32'(sel), 1);
        pulse(B_UP, 1);
        chk_date("clamp", 0, 2, dim(0, 2));
        pulse(B_DN, 2);
        check("mon_wrap", 32'(month), 12);
        pulse(B_LFT, 2);
        check("sel_left", 32'(sel), 2);
        pulse(B_ESC, 1);
        check("esc.norm", 32'(norm), 1);
        check("esc.blink", 32'(blink), 0);
        chk_date("esc_keep", 0, 1, 31);

        do_reset();
        pulse(B_ENT, 1);
        pulse(B_RGT, 2);
        pulse(B_UP, 9);
        chk_date("e5.set", 0, 1, 10);
        pulse(B_TCK, 3);
        chk_date("e5.hidden", 0, 1, 10);
        pulse(B_ESC, 1);
        chk_date("e5.esc", 0, 1, 4);
        pulse(B_ENT, 1);
        chk_date("e5.load", 0, 1, 4);
        pulse(B_RGT, 2);
        pulse(B_UP, 6);
        pulse(B_TCK, 3);
        pulse(B_ENT, 1);
        check("e5.norm", 32'(norm), 1);
        chk_date("e5.commit", 0, 1, 10);

        do_reset();
        pulse(B_ENT, 1);
        pulse(B_RGT, 2);
        drv(B_UP, 1'b1);
        cyc(14);
        check("rpt.day", 32'(day), 4);
        drv(B_UP, 1'b0);
        cyc(1);
        check("rpt.rel", 32'(day), 4);
        drv(B_UP, 1'b1);
        drv(B_ESC, 1'b1);
        cyc(1);
        check("prio.norm", 32'(norm), 1);
        chk_date("prio", 0, 1, 1);
        cyc(10);
        chk_date("prio.hold", 0, 1, 1);
        drv(B_UP, 1'b0);
        drv(B_ESC, 1'b0);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
